// File: rtl/hex_display_pkg.sv
// rtl/hex_display_pkg.sv - shared types and segment table for hex_display_ctrl
package hex_display_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK  = 7'h7F;
  localparam int   MAX_DIGITS = 6;

  // Active-low {g,f,e,d,c,b,a}, indexed by nibble (entry 15 listed first).
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/hex_seg7_dec.sv
// rtl/hex_seg7_dec.sv - combinational nibble to active-low 7-segment decoder
module hex_seg7_dec
  import hex_display_pkg::*;
(
  input  logic [3:0] nibble,
  output seg_t       seg
);

  assign seg = SEG_TABLE[nibble];

endmodule

// File: rtl/hex_display_ctrl.sv
// rtl/hex_display_ctrl.sv - registered multi-digit hex driver with leading-zero blanking
// Blinking (prescaler, blink_phase, blink_mask) exists only when HEX_DISPLAY_BLINK_EN is defined.
module hex_display_ctrl
  import hex_display_pkg::*;
#(
  parameter int NUM_DIGITS = 6,
  parameter int BLINK_DIV  = 25_000_000
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       load,
  input  logic [4*NUM_DIGITS-1:0]    value,
  input  logic                       blank_lz,
  input  logic [NUM_DIGITS-1:0]      blink_mask,
  output logic [NUM_DIGITS-1:0][6:0] hex,
  output logic                       blink_phase
);

  if (NUM_DIGITS < 1 || NUM_DIGITS > MAX_DIGITS) begin : g_bad_digits
    $error("hex_display_ctrl: NUM_DIGITS must be 1..6");
  end
  if (BLINK_DIV < 2) begin : g_bad_div
    $error("hex_display_ctrl: BLINK_DIV must be >= 2");
  end

  logic [4*NUM_DIGITS-1:0]    val_q;
  logic [NUM_DIGITS-1:0][6:0] dec;
  logic [NUM_DIGITS-1:0][6:0] hex_next;
  logic [NUM_DIGITS-1:0]      lz_blank;
  logic [NUM_DIGITS-1:0]      dark;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      val_q <= '0;
    end else if (load) begin
      val_q <= value;
    end
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
    hex_seg7_dec u_dec (
      .nibble (val_q[4*g +: 4]),
      .seg    (dec[g])
    );
  end

  // Scan from the most significant digit; digit 0 is never blanked here.
  always_comb begin
    logic run;
    lz_blank = '0;
    run      = blank_lz;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      if (run && val_q[4*i +: 4] == 4'h0) begin
        lz_blank[i] = 1'b1;
      end else begin
        run = 1'b0;
      end
    end
  end

`ifdef HEX_DISPLAY_BLINK_EN
  localparam int PW = $clog2(BLINK_DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(BLINK_DIV - 1);

  logic [PW-1:0] prescaler;
  logic          phase_q;

  // A load restarts the half-period so a new value is always shown in full first.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prescaler <= '0;
      phase_q   <= 1'b0;
    end else if (load || blink_mask == '0) begin
      prescaler <= '0;
      phase_q   <= 1'b0;
    end else if (prescaler == PRE_LAST) begin
      prescaler <= '0;
      phase_q   <= ~phase_q;
    end else begin
      prescaler <= prescaler + 1'b1;
    end
  end

  assign blink_phase = phase_q;
  assign dark        = phase_q ? blink_mask : '0;
`else
  logic unused_blink_mask;
  assign unused_blink_mask = ^blink_mask;
  assign blink_phase       = 1'b0;
  assign dark              = '0;
`endif

  always_comb begin
    hex_next = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      hex_next[i] = (lz_blank[i] || dark[i]) ? SEG_BLANK : dec[i];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hex <= {NUM_DIGITS{SEG_BLANK}};
    end else begin
      hex <= hex_next;
    end
  end

endmodule
